// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data memory slice.
// Holds the access-size encodings used on req_size and the controller
// state enumeration shared by lsu_data_mem.
package lsu_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SZ_B = 2'b00;  // byte
  localparam logic [1:0] SZ_H = 2'b01;  // half (2 bytes)
  localparam logic [1:0] SZ_W = 2'b10;  // word (4 bytes)
  localparam logic [1:0] SZ_D = 2'b11;  // dword (8 bytes)

  // Controller states: power-up clear sweep, waiting, response cycle.
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage : lsu_pkg

// File: rtl/lsu_align.sv
// Combinational lane alignment for the LSU data memory.
// Ports:
//   size        - access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   is_unsigned - zero-extend loads when 1, sign-extend when 0
//   lane        - byte lane inside the 64-bit word (address[2:0])
//   store_data  - right-justified store data
//   mem_word    - current contents of the addressed memory word
//   misaligned  - lane is not a multiple of the access size
//   byte_en     - bytes of the word touched by a store
//   store_word  - store data shifted up to its lane
//   load_data   - addressed bytes shifted to bit 0 and extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [2:0]  lane,
  input  logic [63:0] store_data,
  input  logic [63:0] mem_word,
  output logic        misaligned,
  output logic [7:0]  byte_en,
  output logic [63:0] store_word,
  output logic [63:0] load_data
);

  logic [63:0] shifted_s;

  // Lane shift in both directions; the shift amount is lane * 8.
  assign shifted_s  = mem_word >> {lane, 3'b000};
  assign store_word = store_data << {lane, 3'b000};

  // Per-size alignment check, byte-enable mask and load extension.
  always_comb begin
    misaligned = 1'b0;
    byte_en    = 8'h00;
    load_data  = 64'd0;
    case (size)
      SZ_B: begin
        misaligned = 1'b0;
        byte_en    = 8'h01 << lane;
        load_data  = is_unsigned ? {56'd0, shifted_s[7:0]}
                                 : {{56{shifted_s[7]}}, shifted_s[7:0]};
      end
      SZ_H: begin
        misaligned = lane[0];
        byte_en    = 8'h03 << lane;
        load_data  = is_unsigned ? {48'd0, shifted_s[15:0]}
                                 : {{48{shifted_s[15]}}, shifted_s[15:0]};
      end
      SZ_W: begin
        misaligned = |lane[1:0];
        byte_en    = 8'h0F << lane;
        load_data  = is_unsigned ? {32'd0, shifted_s[31:0]}
                                 : {{32{shifted_s[31]}}, shifted_s[31:0]};
      end
      SZ_D: begin
        // A full dword has nothing to extend, so is_unsigned is irrelevant.
        misaligned = |lane;
        byte_en    = 8'hFF;
        load_data  = shifted_s;
      end
      default: begin
        misaligned = 1'b1;
        byte_en    = 8'h00;
        load_data  = 64'd0;
      end
    endcase
  end

endmodule : lsu_align

// File: rtl/lsu_data_mem.sv
// LSU data memory: DEPTH x 64-bit word array behind a single-request,
// single-response load/store port. After reset the array is zeroed by a
// sweep of DEPTH cycles during which no request is accepted.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   req_valid    - request present
//   req_ready    - request can be accepted this cycle
//   req_write    - 1 = store, 0 = load
//   req_size     - access size (SZ_B/SZ_H/SZ_W/SZ_D)
//   req_unsigned - zero-extend (1) or sign-extend (0) loads
//   address      - byte address
//   write_data   - right-justified store data
//   rsp_valid    - one-cycle response strobe, the cycle after accept
//   read_data    - extended load result (0 for stores, errors, idle)
//   rsp_error    - request was misaligned or out of range
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] address,
  input  logic [63:0]       write_data,
  output logic              rsp_valid,
  output logic [63:0]       read_data,
  output logic              rsp_error
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int TOP_BIT = IDX_W + 3;  // first byte-address bit beyond the array

  state_e           state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_error_q, rsp_error_d;
  logic [63:0]      read_data_q, read_data_d;

  logic [63:0]      mem [DEPTH];

  logic             accept_s;
  logic             misaligned_s;
  logic             out_of_range_s;
  logic             error_s;
  logic             store_we_s;
  logic             clear_we_s;
  logic [IDX_W-1:0] word_idx_s;
  logic [2:0]       lane_s;
  logic [7:0]       byte_en_s;
  logic [63:0]      mem_word_s;
  logic [63:0]      store_word_s;
  logic [63:0]      load_data_s;

  assign word_idx_s = address[TOP_BIT-1:3];
  assign lane_s     = address[2:0];

  // Any set address bit above the array span means out of range.
  generate
    if (ADDR_W > TOP_BIT) begin : g_range
      assign out_of_range_s = |address[ADDR_W-1:TOP_BIT];
    end else begin : g_no_range
      assign out_of_range_s = 1'b0;
    end
  endgenerate

  // Asynchronous read so the response can be registered in the accept cycle;
  // a store written at one edge is therefore visible to the next request.
  assign mem_word_s = mem[word_idx_s];

  lsu_align u_align (
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .lane        (lane_s),
    .store_data  (write_data),
    .mem_word    (mem_word_s),
    .misaligned  (misaligned_s),
    .byte_en     (byte_en_s),
    .store_word  (store_word_s),
    .load_data   (load_data_s)
  );

  assign accept_s   = req_valid & req_ready_q;
  assign error_s    = misaligned_s | out_of_range_s;
  assign store_we_s = accept_s & req_write & ~error_s;
  assign clear_we_s = (state_q == CLEAR);

  // Next-state logic: clear sweep over every word, then accept/respond.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = {IDX_W{1'b0}};
        end else begin
          state_d   = CLEAR;
          clr_cnt_d = clr_cnt_q + IDX_W'(1);
        end
      end
      IDLE, RESP: begin
        if (accept_s) begin
          state_d = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Response and handshake values, registered at the accept edge. Data and
  // error fall back to 0 on every cycle without a response.
  always_comb begin
    req_ready_d = (state_d != CLEAR);
    rsp_valid_d = accept_s;
    rsp_error_d = accept_s & error_s;
    if (accept_s && !error_s && !req_write) begin
      read_data_d = load_data_s;
    end else begin
      read_data_d = 64'd0;
    end
  end

  // Control and response registers; reset restarts the clear sweep and
  // drops any response that was about to be presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= {IDX_W{1'b0}};
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      read_data_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      read_data_q <= read_data_d;
    end
  end

  // Memory array: zeroed by the clear sweep, byte-masked stores otherwise.
  // The array itself is deliberately not reset.
  always_ff @(posedge clk) begin
    if (clear_we_s) begin
      mem[clr_cnt_q] <= 64'd0;
    end else if (store_we_s) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en_s[b]) begin
          mem[word_idx_s][b*8 +: 8] <= store_word_s[b*8 +: 8];
        end
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign read_data = read_data_q;

endmodule : lsu_data_mem

// File: doc/lsu_data_mem.md
LSU_DATA_MEM -- requirements
Module: lsu_data_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning the number of 64-bit words; legal values are powers of two, 2 to 4096.
REQ-002 SHALL have parameter ADDR_W, default 64, meaning the byte-address width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: the request is present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 dword.
REQ-009 SHALL have port req_unsigned, input, 1 bit: a load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port address, input, ADDR_W bits: the byte address.
REQ-011 SHALL have port write_data, input, 64 bits: the store data, right-justified.
REQ-012 SHALL have port rsp_valid, output, 1 bit: a one-cycle response strobe.
REQ-013 SHALL have port read_data, output, 64 bits: the extended load result.
REQ-014 SHALL have port rsp_error, output, 1 bit: the request was misaligned or out of range.

Function
REQ-015 SHALL implement states CLEAR, IDLE and RESP.
REQ-016 SHALL, in CLEAR, write zero to word clr_cnt each cycle, clr_cnt 0..DEPTH-1, hold req_ready=0, and go to IDLE after exactly DEPTH cycles.
REQ-017 SHALL drive req_ready=1 in IDLE and RESP; a request is accepted when req_valid and req_ready are both 1.
REQ-018 SHALL, on accept, enter RESP; otherwise RESP returns to IDLE.
REQ-019 SHALL assert rsp_valid for exactly one cycle, the cycle after accept, with no backpressure; back-to-back accepts give back-to-back responses.
REQ-020 SHALL form the word index as address[log2(DEPTH)+2:3] and the byte lane as address[2:0].
REQ-021 SHALL flag an error for misalignment (half: address[0]!=0; word: address[1:0]!=0; dword: address[2:0]!=0).
REQ-022 SHALL flag an error for out-of-range addresses (address >= DEPTH*8).
REQ-023 SHALL, on error, leave memory unchanged and respond with rsp_error=1 and read_data=0.
REQ-024 SHALL, on a store, modify only the 1/2/4/8 bytes starting at the lane; the other bytes are preserved; the store response has read_data=0.
REQ-025 SHALL, on a load, shift the addressed bytes to bit 0 and then extend them per req_size/req_unsigned; a dword load ignores req_unsigned.
REQ-026 SHALL, for a load accepted the cycle after a store to the same word, return the post-store data (the write is visible in the next cycle).
REQ-027 SHALL hold read_data and rsp_error at 0 whenever rsp_valid=0.

Reset
REQ-028 SHALL, while rst_n=0, force state=CLEAR, clr_cnt=0, req_ready=0, rsp_valid=0, rsp_error=0 and read_data=0.
REQ-029 SHALL, on reset mid-operation (any state, including mid-CLEAR), discard any pending response and restart the full clear sweep after rst_n rises.
REQ-030 SHALL require no reset of the memory array itself; the clear sweep is the only initialisation.

Structure
REQ-031 SHALL place the size encodings (SZ_B/SZ_H/SZ_W/SZ_D) and the state enum in shared package lsu_pkg.
REQ-032 SHALL place lane shifting, extension and byte-enable generation in one combinational sub-module, lsu_align.
REQ-033 SHALL hold the memory array, clear counter and FSM in lsu_data_mem.

Verification
REQ-034 SHALL cover reset then clear: release rst_n with DEPTH=32 -> req_ready=0 for 32 cycles, then 1; a dword load at address 0x40 returns 0.
REQ-035 SHALL cover a dword store then byte loads: store 0x8877665544332211 to 0x08; lb at 0x0F -> 0xFFFFFFFFFFFFFF88; lbu at 0x0F -> 0x88.
REQ-036 SHALL cover a partial store: store half 0xBEEF to 0x0A -> dword load at 0x08 returns 0x88776655BEEF2211; signed word load at 0x0C returns 0xFFFFFFFF88776655.
REQ-037 SHALL cover errors: word load at 0x06 -> rsp_error=1, read_data=0; dword store at 0x100 (DEPTH=32) -> rsp_error=1 and memory unchanged.
REQ-038 SHALL cover back-to-back operations: store 0x1 to 0x10 then a load from 0x10 on consecutive cycles -> two consecutive rsp_valid pulses, the load returning 0x1.
REQ-039 SHALL cover reset mid-operation: assert rst_n=0 in the cycle a load is accepted -> no rsp_valid, and a full DEPTH-cycle clear follows.
